// File: rtl/fb_reader_if.sv
// Request, pixel-stream and AXI4-Lite read-channel bundle for fb_reader.
// master = the reader itself, slave = the environment around it.
interface fb_reader_if #(
  parameter int PIXEL_BITS     = 12,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16
);
  logic                      req_valid;
  logic                      req_ready;
  logic [AXI_ADDR_WIDTH-1:0] req_addr;
  logic                      pix_valid;
  logic                      pix_ready;
  logic [PIXEL_BITS-1:0]     pix_color;
  logic [AXI_ADDR_WIDTH-1:0] sram_axi_araddr;
  logic                      sram_axi_arvalid;
  logic                      sram_axi_arready;
  logic [AXI_DATA_WIDTH-1:0] sram_axi_rdata;
  logic [1:0]                sram_axi_rresp;
  logic                      sram_axi_rvalid;
  logic                      sram_axi_rready;
  logic                      err;

  modport master (
    input  req_valid, req_addr, pix_ready,
           sram_axi_arready, sram_axi_rdata, sram_axi_rresp, sram_axi_rvalid,
    output req_ready, pix_valid, pix_color,
           sram_axi_araddr, sram_axi_arvalid, sram_axi_rready, err
  );

  modport slave (
    output req_valid, req_addr, pix_ready,
           sram_axi_arready, sram_axi_rdata, sram_axi_rresp, sram_axi_rvalid,
    input  req_ready, pix_valid, pix_color,
           sram_axi_araddr, sram_axi_arvalid, sram_axi_rready, err
  );
endinterface

// File: rtl/fb_reader.sv
// Framebuffer pixel reader: credit-limited AXI4-Lite reads, in-order pixel stream.
// Optional FB_READER_ERR_CHECK_EN: sticky err on bad rresp or unexpected R beat.
module fb_reader #(
  parameter int PIXEL_BITS      = 12,
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic         clk,
  input logic         rst_n,
  fb_reader_if.master bus
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, ADDR} state_t;

  state_t                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic [CW-1:0]             credits_q, credits_d;
  logic [CW-1:0]             inflight_q, inflight_d;
  logic [CW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]             rd_ptr_q, rd_ptr_d;
  logic                      err_q, err_d;
  logic [PIXEL_BITS-1:0]     mem_q [MAX_OUTSTANDING];

  logic credit_ok, req_acc, ar_hs, r_hs, beat_ok, fifo_empty, pop;
  logic unused_in;

  assign credit_ok  = credits_q < CMAX;
  assign req_acc    = bus.req_valid && bus.req_ready;
  assign ar_hs      = arvalid_q && bus.sram_axi_arready;
  assign r_hs       = bus.sram_axi_rvalid && rready_q;
  // A beat with nothing in flight belongs to no request (e.g. issued before reset).
  assign beat_ok    = r_hs && (inflight_q != '0);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign pop        = !fifo_empty && bus.pix_ready;
  assign unused_in  = ^{bus.sram_axi_rdata, bus.sram_axi_rresp};

  assign bus.req_ready        = (state_q == ADDR) ? (bus.sram_axi_arready && credit_ok) : credit_ok;
  assign bus.sram_axi_araddr  = araddr_q;
  assign bus.sram_axi_arvalid = arvalid_q;
  assign bus.sram_axi_rready  = rready_q;
  assign bus.pix_valid        = !fifo_empty;
  assign bus.pix_color        = fifo_empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign bus.err              = err_q;

  // AR channel: a new request may replace the address only on the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_acc) begin
          araddr_q  <= bus.req_addr;
          arvalid_q <= 1'b1;
          state_q   <= ADDR;
        end
        ADDR: if (ar_hs) begin
          if (req_acc) begin
            araddr_q <= bus.req_addr;
          end else begin
            arvalid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    credits_d  = credits_q + CW'(req_acc) - CW'(pop);
    inflight_d = inflight_q + CW'(ar_hs) - CW'(beat_ok);
    wr_ptr_d   = wr_ptr_q + CW'(beat_ok);
    rd_ptr_d   = rd_ptr_q + CW'(pop);
    err_d      = err_q;
`ifdef FB_READER_ERR_CHECK_EN
    if (r_hs && ((bus.sram_axi_rresp != 2'b00) || (inflight_q == '0))) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rready_q   <= 1'b0;
      credits_q  <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      rready_q   <= 1'b1;
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
    end
  end

  // Credits reserve a slot for every issued read, so a write never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (beat_ok) mem_q[wr_ptr_q[PW-1:0]] <= bus.sram_axi_rdata[PIXEL_BITS-1:0];
  end
endmodule

// File: tb/tb_fb_reader.sv
// Self-checking bench for fb_reader: AXI slave model plus in-order pixel scoreboard.
module tb_fb_reader;
  localparam int PB = 12, AW = 20, DW = 16, MO = 4;
`ifdef FB_READER_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_reader_if #(.PIXEL_BITS(PB), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();
  fb_reader #(.PIXEL_BITS(PB), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .MAX_OUTSTANDING(MO))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [AW-1:0] addr; int due; } ar_t;

  int vec = 0, mis = 0, cyc = 0;
  int ar_cnt = 0, acc_edge = -1, slv_lat = 1, cred_m = 0, cred_cur = 0;
  logic arready_ctl = 1'b1, pix_ready_ctl = 1'b1, rnd_pix = 1'b0, rnd_ar = 1'b0;
  logic bad_resp_next = 1'b0, spur_next = 1'b0;
  logic [AW-1:0] src_q[$];
  logic [PB-1:0] exp_q[$];
  ar_t           slv_q[$];
  int            pop_log[$];
  int            acc_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pix_fn(logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hFB9F;
  endfunction

  // Environment: slave, request feeder and pixel scoreboard, all driven on the falling edge.
  initial begin
    logic [DW-1:0] d;
    logic [PB-1:0] e;
    logic acc, pop;
    ar_t ent;
    bus.req_valid = 0; bus.req_addr = '0; bus.pix_ready = 0;
    bus.sram_axi_arready = 0; bus.sram_axi_rdata = '0; bus.sram_axi_rresp = 2'b00; bus.sram_axi_rvalid = 0;
    forever begin
      @(negedge clk);
      bus.sram_axi_arready = rnd_ar ? 1'($urandom_range(0, 1)) : arready_ctl;
      bus.pix_ready        = rnd_pix ? 1'($urandom_range(0, 1)) : pix_ready_ctl;
      bus.sram_axi_rvalid = 0; bus.sram_axi_rresp = 2'b00; bus.sram_axi_rdata = 16'h5A5A;
      if (slv_q.size() > 0 && slv_q[0].due <= cyc) begin
        ent = slv_q.pop_front();
        bus.sram_axi_rvalid = 1; bus.sram_axi_rdata = pix_fn(ent.addr);
        if (bad_resp_next) begin bus.sram_axi_rresp = 2'b10; bad_resp_next = 0; end
      end else if (spur_next) begin
        bus.sram_axi_rvalid = 1; bus.sram_axi_rdata = 16'h0777; spur_next = 0;
      end
      if (bus.sram_axi_arvalid && bus.sram_axi_arready) begin
        ent.addr = bus.sram_axi_araddr; ent.due = cyc + slv_lat;
        slv_q.push_back(ent); ar_cnt++;
      end
      if (src_q.size() > 0) begin bus.req_valid = 1; bus.req_addr = src_q[0]; end
      else begin bus.req_valid = 0; bus.req_addr = '0; end
      #1;
      acc = bus.req_valid && bus.req_ready;
      pop = bus.pix_valid && bus.pix_ready;
      if (acc) begin
        d = pix_fn(src_q.pop_front()); exp_q.push_back(d[PB-1:0]);
        acc_edge = cyc + 1; acc_log.push_back(cyc);
      end
      if (pop) begin
        vec++;
        if (exp_q.size() == 0) begin
          mis++; $display("FAIL pix_order: pixel %h popped, none expected", bus.pix_color);
        end else begin
          e = exp_q.pop_front();
          if (bus.pix_color !== e) begin mis++; $display("FAIL pix_order: got %h want %h", bus.pix_color, e); end
        end
        pop_log.push_back(cyc);
      end
      cred_cur = cred_m;
      cred_m   = cred_m + int'(acc) - int'(pop);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc_wait(int n);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic drain(string nm);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || slv_q.size() != 0 || bus.pix_valid) && n < 300) begin
      cyc_wait(1); n++;
    end
    vec++;
    if (n >= 300) begin mis++; $display("FAIL %s_drain: timeout, pending %0d want 0", nm, exp_q.size()); end
  endtask

  task automatic do_reset();
    @(negedge clk); #3; rst_n = 0;
    src_q.delete(); exp_q.delete(); cred_m = 0;
    cyc_wait(2); rst_n = 1; cyc_wait(2);
  endtask

  task automatic test_reset();
    rst_n = 0;
    cyc_wait(3);
    vec++; if (bus.sram_axi_arvalid !== 0) begin mis++; $display("FAIL rst_arvalid: got %b want 0", bus.sram_axi_arvalid); end
    vec++; if (bus.sram_axi_araddr !== '0) begin mis++; $display("FAIL rst_araddr: got %h want 0", bus.sram_axi_araddr); end
    vec++; if (bus.sram_axi_rready !== 0) begin mis++; $display("FAIL rst_rready: got %b want 0", bus.sram_axi_rready); end
    vec++; if (bus.pix_valid !== 0 || bus.pix_color !== '0) begin mis++; $display("FAIL rst_pix: got %b/%h want 0/0", bus.pix_valid, bus.pix_color); end
    vec++; if (bus.err !== 0) begin mis++; $display("FAIL rst_err: got %b want 0", bus.err); end
    rst_n = 1;
    cyc_wait(1);
    vec++; if (bus.req_ready !== 1 || bus.sram_axi_rready !== 1) begin mis++; $display("FAIL rst_release: req_ready/rready got %b/%b want 1/1", bus.req_ready, bus.sram_axi_rready); end
  endtask

  task automatic test_single();
    int t_ar = -1, t_pix = -1;
    logic [PB-1:0] c = '0;
    acc_edge = -1;
    src_q.push_back(20'h00123);
    for (int k = 0; k < 12; k++) begin
      cyc_wait(1);
      if (bus.sram_axi_arvalid && t_ar < 0) t_ar = cyc;
      if (bus.pix_valid && t_pix < 0) begin t_pix = cyc; c = bus.pix_color; end
    end
    // accepted at edge N: arvalid in the cycle after N, pixel two cycles later
    vec++; if (t_ar - acc_edge !== 0) begin mis++; $display("FAIL single_ar_lat: got %0d want 0", t_ar - acc_edge); end
    vec++; if (t_pix - acc_edge !== 2) begin mis++; $display("FAIL single_pix_lat: got %0d want 2", t_pix - acc_edge); end
    vec++; if (c !== 12'hABC) begin mis++; $display("FAIL single_color: got %h want abc", c); end
    vec++; if (int'(dut.credits_q) !== 0) begin mis++; $display("FAIL single_credits: got %0d want 0", dut.credits_q); end
  endtask

  task automatic test_burst();
    int ar0 = ar_cnt;
    logic [PB-1:0] head;
    pix_ready_ctl = 0; pop_log.delete();
    for (int i = 0; i < 6; i++) src_q.push_back(AW'(20'h01000 + i * 3));
    cyc_wait(10);
    vec++; if (ar_cnt - ar0 !== 4) begin mis++; $display("FAIL burst_ar_cnt: got %0d want 4", ar_cnt - ar0); end
    vec++; if (bus.req_ready !== 0) begin mis++; $display("FAIL burst_req_ready: got %b want 0", bus.req_ready); end
    vec++; if (exp_q.size() !== 4 || src_q.size() !== 2) begin mis++; $display("FAIL burst_accepts: got %0d/%0d want 4/2", exp_q.size(), src_q.size()); end
    vec++; if (int'(dut.credits_q) !== MO) begin mis++; $display("FAIL burst_credits: got %0d want %0d", dut.credits_q, MO); end
    head = exp_q[0];
    vec++; if (bus.pix_color !== head) begin mis++; $display("FAIL burst_head: got %h want %h", bus.pix_color, head); end
    cyc_wait(2);
    vec++; if (bus.pix_color !== head || bus.pix_valid !== 1) begin mis++; $display("FAIL burst_stable: got %h want %h", bus.pix_color, head); end
    pix_ready_ctl = 1;
    drain("burst");
    vec++; if (ar_cnt - ar0 !== 6 || pop_log.size() !== 6) begin mis++; $display("FAIL burst_total: ar %0d pops %0d want 6/6", ar_cnt - ar0, pop_log.size()); end
  endtask

  task automatic test_arready_stall();
    int ar0 = ar_cnt;
    arready_ctl = 0;
    src_q.push_back(20'hABCDE); src_q.push_back(20'h13579);
    cyc_wait(2);
    for (int k = 0; k < 5; k++) begin
      vec++;
      if (bus.sram_axi_arvalid !== 1 || bus.sram_axi_araddr !== 20'hABCDE || bus.req_ready !== 0) begin
        mis++; $display("FAIL stall_hold: arvalid/araddr/req_ready got %b/%h/%b want 1/abcde/0",
                        bus.sram_axi_arvalid, bus.sram_axi_araddr, bus.req_ready);
      end
      cyc_wait(1);
    end
    vec++; if (ar_cnt - ar0 !== 0) begin mis++; $display("FAIL stall_no_hs: got %0d want 0", ar_cnt - ar0); end
    arready_ctl = 1;
    cyc_wait(1);
    vec++; if (ar_cnt - ar0 !== 1) begin mis++; $display("FAIL stall_release_hs: got %0d want 1", ar_cnt - ar0); end
    drain("stall");
    vec++; if (ar_cnt - ar0 !== 2) begin mis++; $display("FAIL stall_total: got %0d want 2", ar_cnt - ar0); end
  endtask

  task automatic test_back_to_back();
    pop_log.delete(); acc_log.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(AW'(20'h40000 + i * 17));
    drain("b2b");
    vec++;
    if (pop_log.size() !== 8 || acc_log.size() !== 8) begin
      mis++; $display("FAIL b2b_count: pops %0d accepts %0d want 8/8", pop_log.size(), acc_log.size());
    end else if (pop_log[7] - pop_log[0] !== 7 || acc_log[7] - acc_log[0] !== 7) begin
      mis++; $display("FAIL b2b_rate: pop span %0d accept span %0d want 7/7", pop_log[7] - pop_log[0], acc_log[7] - acc_log[0]);
    end
  endtask

  task automatic test_credit_random();
    rnd_pix = 1; rnd_ar = 1;
    for (int k = 0; k < 100; k++) begin
      if (src_q.size() < 2) src_q.push_back(AW'($urandom_range(0, (1 << AW) - 1)));
      cyc_wait(1);
      vec++;
      if (int'(dut.credits_q) !== cred_cur) begin mis++; $display("FAIL credit_track: got %0d want %0d", dut.credits_q, cred_cur); end
    end
    rnd_pix = 0; rnd_ar = 0; pix_ready_ctl = 1; arready_ctl = 1;
    drain("credit");
  endtask

  task automatic test_reset_midop();
    int ar0 = ar_cnt, n = 0, bad = 0;
    pix_ready_ctl = 0; slv_lat = 6;
    for (int i = 0; i < 3; i++) src_q.push_back(AW'(20'h77700 + i));
    while (ar_cnt - ar0 < 3 && n < 20) begin cyc_wait(1); n++; end
    cyc_wait(1);
    #1; rst_n = 0; #1;
    vec++;
    if (bus.sram_axi_arvalid !== 0 || bus.pix_valid !== 0 || bus.sram_axi_rready !== 0 || bus.err !== 0 || bus.sram_axi_araddr !== '0) begin
      mis++; $display("FAIL midrst_async: arvalid/pix_valid/rready/err got %b/%b/%b/%b want 0/0/0/0",
                      bus.sram_axi_arvalid, bus.pix_valid, bus.sram_axi_rready, bus.err);
    end
    src_q.delete(); exp_q.delete(); cred_m = 0; pix_ready_ctl = 1;
    cyc_wait(2); rst_n = 1;
    for (int k = 0; k < 12; k++) begin cyc_wait(1); if (bus.pix_valid !== 0) bad++; end
    vec++; if (bad != 0 || slv_q.size() != 0) begin mis++; $display("FAIL midrst_drop: pix_valid seen %0d cycles want 0", bad); end
    vec++; if (bus.err !== ERR_EN) begin mis++; $display("FAIL midrst_err: got %b want %b", bus.err, ERR_EN); end
    slv_lat = 1;
  endtask

  task automatic test_err_resp();
    int n = 0;
    do_reset();
    pop_log.delete();
    bad_resp_next = 1;
    src_q.push_back(20'h00456);
    while (bad_resp_next && n < 20) begin cyc_wait(1); n++; end
    vec++; if (bus.err !== 0 || n >= 20) begin mis++; $display("FAIL resp_err_before: got %b want 0", bus.err); end
    cyc_wait(1);
    vec++; if (bus.err !== ERR_EN) begin mis++; $display("FAIL resp_err: got %b want %b", bus.err, ERR_EN); end
    drain("resp");
    vec++; if (pop_log.size() !== 1) begin mis++; $display("FAIL resp_delivered: got %0d pixels want 1", pop_log.size()); end
  endtask

  task automatic test_spurious();
    int n = 0, bad = 0;
    do_reset();
    pop_log.delete();
    spur_next = 1;
    while (spur_next && n < 20) begin cyc_wait(1); n++; end
    vec++; if (bus.err !== 0 || n >= 20) begin mis++; $display("FAIL spur_err_before: got %b want 0", bus.err); end
    cyc_wait(1);
    vec++; if (bus.err !== ERR_EN) begin mis++; $display("FAIL spur_err: got %b want %b", bus.err, ERR_EN); end
    for (int k = 0; k < 4; k++) begin if (bus.pix_valid !== 0) bad++; cyc_wait(1); end
    vec++; if (bad != 0 || pop_log.size() != 0) begin mis++; $display("FAIL spur_drop: pix_valid %0d cycles, pops %0d want 0/0", bad, pop_log.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_arready_stall();
    test_back_to_back();
    test_credit_random();
    test_reset_midop();
    test_err_resp();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
